waterbear_param_core: RTL and testbench

WATERBEAR_PARAM_CORE -- requirements
Module: waterbear_param_core

---
 rtl/waterbear_param_core.sv | 138 +++++++++++++
 tb/tb_waterbear_param_core.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/waterbear_param_core.sv
// rtl/waterbear_param_core.sv - parameterised two-cycle accumulator core
//
// Purpose: small accumulator machine with four general registers. Each
// instruction is fetched in one cycle (FETCH) and executed in the next (EXEC).
// Opcode F parks the core in HALT until reset.
//
// Ports:
//   clk     in   1      sole clock, rising edge
//   reset   in   1      asynchronous, active-high reset
//   pc      out  AW     program counter / instruction address
//   instr   in   DW+6   {opcode[3:0], rsel[1:0], imm[DW-1:0]} at address pc
//   acc     out  DW     accumulator
//   zf      out  1      zero flag
//   cf      out  1      carry/borrow flag
//   halted  out  1      high while in HALT
module waterbear_param_core #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    output logic [AW-1:0] pc,
    input  logic [DW+5:0] instr,
    output logic [DW-1:0] acc,
    output logic          zf,
    output logic          cf,
    output logic          halted
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [DW+5:0]   ir, ir_n;
    logic [DW-1:0]   rf [4];
    logic [AW-1:0]   pc_n;
    logic [DW-1:0]   acc_n;
    logic            zf_n, cf_n;
    logic            rf_we;

    logic [3:0]      opcode;
    logic [1:0]      rsel;
    logic [DW-1:0]   imm;
    logic [DW-1:0]   rv;
    logic [DW:0]     sum_r, sum_i, diff_r;
    logic [AW-1:0]   pc_inc;

    assign opcode = ir[DW+5:DW+2];
    assign rsel   = ir[DW+1:DW];
    assign imm    = ir[DW-1:0];
    assign rv     = rf[rsel];

    // One extra bit on each operand so the top bit of the result is the
    // carry (add) or the unsigned borrow (subtract).
    assign sum_r  = {1'b0, acc} + {1'b0, rv};
    assign sum_i  = {1'b0, acc} + {1'b0, imm};
    assign diff_r = {1'b0, acc} - {1'b0, rv};
    assign pc_inc = pc + AW'(1);

    assign halted = (state == S_HALT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
            pc    <= '0;
            acc   <= '0;
            zf    <= 1'b0;
            cf    <= 1'b0;
            ir    <= '0;
            for (int i = 0; i < 4; i++) begin
                rf[i] <= '0;
            end
        end else begin
            state <= state_n;
            pc    <= pc_n;
            acc   <= acc_n;
            zf    <= zf_n;
            cf    <= cf_n;
            ir    <= ir_n;
            if (rf_we) begin
                rf[rsel] <= acc;
            end
        end
    end

    always_comb begin
        logic acc_wr;
        state_n = state;
        ir_n    = ir;
        pc_n    = pc;
        acc_n   = acc;
        zf_n    = zf;
        cf_n    = cf;
        rf_we   = 1'b0;
        acc_wr  = 1'b0;

        case (state)
            S_FETCH: begin
                ir_n    = instr;
                state_n = S_EXEC;
            end
            S_EXEC: begin
                state_n = S_FETCH;
                pc_n    = pc_inc;
                case (opcode)
                    4'h0: ;
                    4'h1: begin acc_n = imm;                 acc_wr = 1'b1; end
                    4'h2: begin acc_n = sum_r[DW-1:0];  cf_n = sum_r[DW];  acc_wr = 1'b1; end
                    4'h3: begin acc_n = diff_r[DW-1:0]; cf_n = diff_r[DW]; acc_wr = 1'b1; end
                    4'h4: begin acc_n = acc & rv;            acc_wr = 1'b1; end
                    4'h5: begin acc_n = acc | rv;            acc_wr = 1'b1; end
                    4'h6: begin acc_n = acc ^ rv;            acc_wr = 1'b1; end
                    4'h7: rf_we = 1'b1;
                    4'h8: begin acc_n = rv;                  acc_wr = 1'b1; end
                    4'h9: pc_n = imm[AW-1:0];
                    4'hA: if (zf) pc_n = imm[AW-1:0];
                    4'hB: if (cf) pc_n = imm[AW-1:0];
                    4'hC: begin acc_n = sum_i[DW-1:0];  cf_n = sum_i[DW];  acc_wr = 1'b1; end
                    4'hD: begin acc_n = {acc[DW-2:0], 1'b0}; cf_n = acc[DW-1]; acc_wr = 1'b1; end
                    4'hE: begin acc_n = {1'b0, acc[DW-1:1]}; cf_n = acc[0];    acc_wr = 1'b1; end
                    default: begin
                        // HALT: pc stays on the HALT instruction's address.
                        pc_n    = pc;
                        state_n = S_HALT;
                    end
                endcase
                if (acc_wr) begin
                    zf_n = (acc_n == '0);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_waterbear_param_core.sv
// tb/tb_waterbear_param_core.sv - directed self-checking bench for waterbear_param_core
module tb_waterbear_param_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  pc;
    logic [13:0] instr;
    logic [7:0]  acc;
    logic        zf, cf, halted;

    logic [13:0] prog [256];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign instr = prog[pc];

    waterbear_param_core #(.DW(8), .AW(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .pc     (pc),
        .instr  (instr),
        .acc    (acc),
        .zf     (zf),
        .cf     (cf),
        .halted (halted)
    );

    function automatic logic [13:0] ins(input logic [3:0] op, input logic [1:0] rs, input logic [7:0] im);
        return {op, rs, im};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold reset, fill the program store with HALT; caller loads the program
    // and then calls release_reset.
    task automatic hold_reset();
        reset = 1'b1;
        for (int i = 0; i < 256; i++) prog[i] = ins(4'hF, 2'd0, 8'h00);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        hold_reset();
        chk("rst_pc", pc, 0);
        chk("rst_acc", acc, 0);
        chk("rst_zf", zf, 0);
        chk("rst_cf", cf, 0);
        chk("rst_halted", halted, 0);

        // LDI FF ; ADDI 01 -> wrap to zero with carry
        prog[0] = ins(4'h1, 2'd0, 8'hFF);
        prog[1] = ins(4'hC, 2'd0, 8'h01);
        release_reset();
        step(1);
        chk("fetch_pc_hold", pc, 8'h00);
        chk("fetch_acc_hold", acc, 8'h00);
        step(1);
        chk("ldi_acc", acc, 8'hFF);
        chk("ldi_pc", pc, 8'h01);
        step(2);
        chk("addi_acc", acc, 8'h00);
        chk("addi_zf", zf, 1);
        chk("addi_cf", cf, 1);
        chk("addi_pc", pc, 8'h02);

        // LDI 5 ; MOV R1 ; LDI 3 ; SUB R1 ; LDR R1
        hold_reset();
        prog[0] = ins(4'h1, 2'd0, 8'h05);
        prog[1] = ins(4'h7, 2'd1, 8'h00);
        prog[2] = ins(4'h1, 2'd0, 8'h03);
        prog[3] = ins(4'h3, 2'd1, 8'h00);
        prog[4] = ins(4'h8, 2'd1, 8'h00);
        release_reset();
        step(8);
        chk("sub_acc", acc, 8'hFE);
        chk("sub_cf", cf, 1);
        chk("sub_zf", zf, 0);
        chk("sub_pc", pc, 8'h04);
        step(2);
        chk("ldr_r1", acc, 8'h05);
        chk("ldr_cf_hold", cf, 1);
        chk("ldr_pc", pc, 8'h05);

        // LDI 0 ; JZ 10 ; @10 LDI 1 ; JZ 20 ; ADDI FF ; JC 30
        hold_reset();
        prog[8'h00] = ins(4'h1, 2'd0, 8'h00);
        prog[8'h01] = ins(4'hA, 2'd0, 8'h10);
        prog[8'h10] = ins(4'h1, 2'd0, 8'h01);
        prog[8'h11] = ins(4'hA, 2'd0, 8'h20);
        prog[8'h12] = ins(4'hC, 2'd0, 8'hFF);
        prog[8'h13] = ins(4'hB, 2'd0, 8'h30);
        release_reset();
        step(4);
        chk("jz_taken_pc", pc, 8'h10);
        step(4);
        chk("jz_not_taken_pc", pc, 8'h12);
        chk("jz_acc", acc, 8'h01);
        step(2);
        chk("addi_ff_acc", acc, 8'h00);
        chk("addi_ff_cf", cf, 1);
        step(2);
        chk("jc_taken_pc", pc, 8'h30);

        // JMP FF ; @FF NOP -> pc wraps to 0
        hold_reset();
        prog[8'h00] = ins(4'h9, 2'd0, 8'hFF);
        prog[8'hFF] = ins(4'h0, 2'd0, 8'h00);
        release_reset();
        step(2);
        chk("jmp_pc", pc, 8'hFF);
        step(2);
        chk("wrap_pc", pc, 8'h00);

        // Shifts and logic ops, plus instr change during EXEC
        hold_reset();
        prog[0] = ins(4'h1, 2'd0, 8'h81);
        prog[1] = ins(4'hD, 2'd0, 8'h00);
        prog[2] = ins(4'hE, 2'd0, 8'h00);
        prog[3] = ins(4'h7, 2'd2, 8'h00);
        prog[4] = ins(4'h1, 2'd0, 8'h0F);
        prog[5] = ins(4'h6, 2'd2, 8'h00);
        prog[6] = ins(4'h5, 2'd2, 8'h00);
        prog[7] = ins(4'h4, 2'd2, 8'h00);
        prog[8] = ins(4'hE, 2'd0, 8'h00);
        release_reset();
        step(4);
        chk("shl_acc", acc, 8'h02);
        chk("shl_cf", cf, 1);
        step(2);
        chk("shr_acc", acc, 8'h01);
        chk("shr_cf", cf, 0);
        step(3);
        prog[4] = ins(4'h1, 2'd0, 8'hAA);
        step(1);
        chk("exec_ignores_instr", acc, 8'h0F);
        step(2);
        chk("xor_acc", acc, 8'h0E);
        step(2);
        chk("or_acc", acc, 8'h0F);
        step(2);
        chk("and_acc", acc, 8'h01);
        step(2);
        chk("shr_zero_acc", acc, 8'h00);
        chk("shr_zero_cf", cf, 1);
        chk("shr_zero_zf", zf, 1);

        // HALT at 0x04, hold for 20 edges, then asynchronous reset
        hold_reset();
        prog[0] = ins(4'h1, 2'd0, 8'h42);
        prog[1] = ins(4'h0, 2'd0, 8'h00);
        prog[2] = ins(4'h0, 2'd0, 8'h00);
        prog[3] = ins(4'hC, 2'd0, 8'h01);
        prog[4] = ins(4'hF, 2'd0, 8'h00);
        release_reset();
        step(10);
        chk("halt_halted", halted, 1);
        chk("halt_pc", pc, 8'h04);
        chk("halt_acc", acc, 8'h43);
        for (int i = 0; i < 20; i++) begin
            prog[4] = ins(4'(i % 15), 2'(i), 8'(i * 37));
            step(1);
            chk("halt_hold_pc", pc, 8'h04);
            chk("halt_hold_acc", acc, 8'h43);
            chk("halt_hold_halted", halted, 1);
        end
        reset = 1'b1;
        #1;
        chk("halt_rst_pc", pc, 8'h00);
        chk("halt_rst_halted", halted, 0);

        // Reset in the middle of EXEC of ADDI with acc = 7F
        hold_reset();
        prog[0] = ins(4'h1, 2'd0, 8'h7F);
        prog[1] = ins(4'hC, 2'd0, 8'h01);
        release_reset();
        step(3);
        chk("pre_rst_acc", acc, 8'h7F);
        reset = 1'b1;
        #1;
        chk("mid_rst_acc", acc, 8'h00);
        chk("mid_rst_zf", zf, 0);
        chk("mid_rst_cf", cf, 0);
        chk("mid_rst_pc", pc, 8'h00);
        release_reset();
        step(2);
        chk("restart_acc", acc, 8'h7F);
        chk("restart_pc", pc, 8'h01);
        step(2);
        chk("restart_addi_acc", acc, 8'h80);
        chk("restart_addi_cf", cf, 0);
        chk("restart_addi_zf", zf, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
